// File: rtl/alu_control_mdu_pkg.sv
// Shared constants for the EX-stage ALU control decoder and the iterative MDU.
package alu_control_mdu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MDU = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_RTYPE = 2'b10, OP_AND = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000, F_SUB   = 6'b100010, F_AND  = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101, F_SLT   = 6'b101010, F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLL   = 6'b000000, F_SRL   = 6'b000010, F_SRA  = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010, F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} mdu_state_e;

  function automatic logic is_mdu(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction
endpackage

// File: rtl/alu_control_mdu_if.sv
// EX-stage bus between the pipeline and the ALU control / MDU block.
interface alu_control_mdu_if #(parameter int WIDTH = 32);
  logic [1:0]       op;
  logic [5:0]       funct;
  logic             valid;
  logic             flush;
  logic [WIDTH-1:0] a, b;
  logic [3:0]       control;
  logic             illegal;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi, lo;

  modport master (output op, funct, valid, flush, a, b,
                  input  control, illegal, stall, done, hi, lo);
  modport slave  (input  op, funct, valid, flush, a, b,
                  output control, illegal, stall, done, hi, lo);
endinterface

// File: rtl/alu_control_mdu_core.sv
// Iterative MDU datapath: shift-add multiply, restoring divide, sign fix-up on magnitudes.
module mdu_core #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             cnt_zero_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, dv_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q, neg_hi_q, neg_lo_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, sh;
  logic [2*WIDTH-1:0] res;

  assign a_neg = sgn_i & a_i[WIDTH-1];
  assign b_neg = sgn_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  always_comb begin
    acc_d = acc_q;
    lo_d  = lo_q;
    sum   = '0;
    sh    = '0;
    if (div_q) begin
      sh = {acc_q, lo_q[WIDTH-1]};
      if (sh >= {1'b0, dv_q}) begin
        acc_d = WIDTH'(sh - {1'b0, dv_q});
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = sh[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? dv_q : {WIDTH{1'b0}})};
      acc_d = sum[WIDTH:1];
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    res = {acc_q, lo_q};
    if (!div_q) begin
      if (neg_lo_q) res = -res;
    end else begin
      if (neg_hi_q) res[2*WIDTH-1:WIDTH] = -acc_q;
      if (neg_lo_q) res[WIDTH-1:0]       = -lo_q;
    end
  end

  assign res_hi_o   = res[2*WIDTH-1:WIDTH];
  assign res_lo_o   = res[WIDTH-1:0];
  assign cnt_zero_o = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0; lo_q <= '0; dv_q <= '0; cnt_q <= '0;
      div_q <= 1'b0; neg_hi_q <= 1'b0; neg_lo_q <= 1'b0;
    end else if (load_i) begin
      div_q <= is_div_i;
      cnt_q <= CNT_W'(WIDTH-1);
      // Divide by zero preloads the architectural answer so FIX only has to copy it out.
      if (is_div_i && b_i == '0) begin
        acc_q <= a_i; lo_q <= '1; dv_q <= '0;
        neg_hi_q <= 1'b0; neg_lo_q <= 1'b0;
      end else begin
        acc_q <= '0; lo_q <= a_mag; dv_q <= b_mag;
        neg_lo_q <= a_neg ^ b_neg;
        neg_hi_q <= is_div_i ? a_neg : (a_neg ^ b_neg);
      end
    end else if (step_i) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decode plus MDU sequencing, HI/LO ownership and hazard stall.
module alu_control_mdu
  import alu_control_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  alu_control_mdu_if.slave bus
);
  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
  logic             done_q, wr, step, accept, mdu_op, cnt_zero;
  logic [3:0]       ctrl;
  logic             ill;

  always_comb begin
    ctrl = ALU_ILL;
    ill  = 1'b0;
    case (bus.op)
      OP_ADD: ctrl = ALU_ADD;
      OP_SUB: ctrl = ALU_SUB;
      OP_AND: ctrl = ALU_AND;
      default: begin
        case (bus.funct)
          F_ADD: ctrl = ALU_ADD;
          F_SUB: ctrl = ALU_SUB;
          F_AND: ctrl = ALU_AND;
          F_OR:  ctrl = ALU_OR;
          F_SLT: ctrl = ALU_SLT;
          F_NOR: ctrl = ALU_NOR;
          F_SLL: ctrl = ALU_SLL;
          F_SRL: ctrl = ALU_SRL;
          F_SRA: ctrl = ALU_SRA;
          F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl = ALU_MDU;
          default: begin ctrl = ALU_ILL; ill = 1'b1; end
        endcase
      end
    endcase
  end

  assign mdu_op = bus.valid & (bus.op == OP_RTYPE) & is_mdu(bus.funct);
  assign accept = mdu_op & ~bus.flush & (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    wr      = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = (bus.funct[1] && bus.b == '0) ? S_FIX : S_RUN;
      S_RUN: begin
        step = 1'b1;
        if (bus.flush)    state_d = S_IDLE;
        else if (cnt_zero) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        wr      = ~bus.flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .step_i    (step),
    .is_div_i  (bus.funct[1]),
    .sgn_i     (~bus.funct[0]),
    .a_i       (bus.a),
    .b_i       (bus.b),
    .cnt_zero_o(cnt_zero),
    .res_hi_o  (res_hi),
    .res_lo_o  (res_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= wr;
      if (wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.control = ctrl;
  assign bus.illegal = ill;
  assign bus.stall   = (state_q != S_IDLE) | (mdu_op & (state_q != S_IDLE));
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_alu_control_mdu.sv
// Scoreboard bench for alu_control_mdu: decode table, MDU results, latency, stall, flush, reset.
module tb_alu_control_mdu;
  import alu_control_mdu_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_control_mdu_if #(.WIDTH(W)) bus();
  alu_control_mdu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] hi, lo;
    int due, stalls;
  } exp_t;

  exp_t scb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0, cyc = 0, st_cnt = 0, done_cnt = 0;
  logic [12:0] dtab [17];
  logic [5:0]  fl [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] pa, pb;
    logic signed [W-1:0] sa, sbb, q, r;
    sa = a; sbb = b;
    pa = {{W{a[W-1]}}, a};
    pb = {{W{b[W-1]}}, b};
    case (f)
      F_MULT:  return pa * pb;
      F_MULTU: return {32'b0, a} * {32'b0, b};
      F_DIV: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sbb; r = sa % sbb;
        return {r, q};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (bus.stall) st_cnt++;
    if (bus.done) begin
      done_cnt++;
      chk("done_expected", 64'(scb.size() != 0), 64'd1);
      if (scb.size() != 0) begin
        e = scb.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("latency", cyc, e.due);
        chk("stall_cycles", st_cnt, e.stalls);
      end
      st_cnt = 0;
    end
  end

  task automatic present(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic flu);
    bus.valid = 1'b1; bus.op = OP_RTYPE; bus.funct = f;
    bus.a = a; bus.b = b; bus.flush = flu;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.flush = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    logic [63:0] m;
    logic z;
    m = model(f, a, b);
    z = f[1] && (b == '0);
    x.hi = m[63:32]; x.lo = m[31:0];
    x.due = cyc + (z ? 2 : W + 2);
    x.stalls = z ? 1 : W + 1;
    scb.push_back(x);
    present(f, a, b, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && scb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(scb.size()), 64'd0);
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] ph, pl;
    int d0;
    bus.valid = 1'b0; bus.flush = 1'b0; bus.op = OP_ADD; bus.funct = '0; bus.a = '0; bus.b = '0;
    fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    dtab = '{13'b00_000000_0010_0, 13'b01_000000_0110_0, 13'b11_000000_0000_0,
             13'b10_100000_0010_0, 13'b10_100010_0110_0, 13'b10_100100_0000_0,
             13'b10_100101_0001_0, 13'b10_101010_0111_0, 13'b10_100111_1100_0,
             13'b10_000000_0011_0, 13'b10_000010_0100_0, 13'b10_000011_0101_0,
             13'b10_011000_1000_0, 13'b10_011011_1000_0, 13'b10_111111_1111_1,
             13'b10_011100_1111_1, 13'b00_111111_0010_0};

    repeat (3) @(negedge clk);
    chk("rst_hi", bus.hi, 0); chk("rst_lo", bus.lo, 0);
    chk("rst_done", bus.done, 0); chk("rst_stall", bus.stall, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      logic [12:0] t;
      t = dtab[i];
      bus.op = t[12:11]; bus.funct = t[10:5];
      #1;
      chk($sformatf("ctrl%0d", i), bus.control, t[4:1]);
      chk($sformatf("illegal%0d", i), bus.illegal, t[0]);
    end
    bus.op = OP_RTYPE; bus.funct = F_MULT;
    repeat (3) @(negedge clk);
    chk("valid0_no_start", bus.stall, 0);

    align(); issue(F_MULT, 32'hFFFF_FFFD, 32'd7); drain();
    chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF); chk("mult_lo_const", bus.lo, 32'hFFFF_FFEB);
    align(); issue(F_MULTU, 32'hFFFF_FFFF, 32'd2); drain();
    align(); issue(F_DIV, 32'hFFFF_FFF9, 32'd2); drain();
    chk("div_lo_const", bus.lo, 32'hFFFF_FFFD); chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    align(); issue(F_DIVU, 32'd7, 32'd2); drain();
    align(); issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF); drain();
    align(); issue(F_DIVU, 32'd5, 32'd0); drain();
    chk("div0_lo_const", bus.lo, 32'hFFFF_FFFF); chk("div0_hi_const", bus.hi, 32'd5);
    align(); issue(F_DIV, 32'hFFFF_FFF7, 32'd0); drain();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = (i % 2 == 1) ? W'($urandom_range(1, 1000)) : W'($urandom);
      align(); issue(fl[i % 4], ra, rb); drain();
    end

    align(); issue(F_MULT, 32'd5, 32'd6);
    for (int i = 0; i < 100 && !bus.done; i++) begin @(posedge clk); #1; end
    chk("b2b_done_cycle_idle", bus.stall, 0);
    issue(F_MULT, 32'hFFFF_FC18, 32'd12345);
    chk("b2b_accepted", bus.stall, 1);
    drain();

    align(); issue(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (8) begin @(posedge clk); #1; end
    bus.valid = 1'b1; bus.op = OP_RTYPE; bus.funct = F_DIVU; bus.a = 32'd99; bus.b = 32'd3;
    @(negedge clk); chk("busy_stall", bus.stall, 1);
    @(posedge clk); #1 bus.valid = 1'b0;
    drain();
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    chk("midrun_not_accepted", bus.stall, 0);
    chk("midrun_no_extra_done", done_cnt, d0);

    ph = bus.hi; pl = bus.lo; d0 = done_cnt;
    align(); present(F_MULT, 32'd123, 32'd456, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("flush_idle", bus.stall, 0);
    repeat (40) @(negedge clk);
    chk("flush_no_done", done_cnt, d0);
    chk("flush_hi", bus.hi, ph); chk("flush_lo", bus.lo, pl);
    st_cnt = 0;

    align(); present(F_MULT, 32'd3, 32'd3, 1'b1);
    chk("flush_accept_rejected", bus.stall, 0);
    repeat (40) @(negedge clk);
    chk("flush_accept_no_done", done_cnt, d0);

    align(); present(F_DIV, 32'd100, 32'd7, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    chk("rst_mid_hi", bus.hi, 0); chk("rst_mid_lo", bus.lo, 0); chk("rst_mid_stall", bus.stall, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, d0);
    chk("rst_mid_lo_after", bus.lo, 0);
    st_cnt = 0;

    align(); issue(F_DIVU, 32'd100, 32'd7); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
